// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: latches level/edge requests, picks one winner and
// runs the signal -> acknowledge -> return handshake with the core's trap logic.
module irq_arbiter #(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic [N_SRC-1:0] int_req_i,
  input  logic [N_SRC-1:0] mie_i,
  input  logic [N_SRC-1:0] edge_i,
  input  logic             gie_i,
  input  logic             trap_ack_i,
  input  logic             int_ret_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_SRC-1:0] int_fin_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, SIGNAL, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [N_SRC-1:0]   pend, pend_nxt, prev, elig;
  logic [2*N_SRC-1:0] elig_rot;
  logic [ID_W-1:0]    rr_ptr, cur_id, win_id, cur_inc;
  logic [ID_W:0]      win_sum;
  logic               win_vld;
  logic               ack_fire, ret_fire;

  assign ack_fire = (state == SIGNAL) && trap_ack_i;
  assign ret_fire = (state == ACTIVE) && int_ret_i;
  assign elig     = pend & mie_i & {N_SRC{gie_i}};
  assign cur_inc  = (cur_id == ID_W'(N_SRC - 1)) ? '0 : cur_id + 1'b1;

  // Rotate the eligible vector so bit 0 is rr_ptr; first set bit is the winner offset.
  always_comb begin
    elig_rot = {elig, elig} >> rr_ptr;
    win_vld  = 1'b0;
    win_sum  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!win_vld && elig_rot[k]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      end
    end
    if (win_sum >= (ID_W + 1)'(N_SRC))
      win_sum = win_sum - (ID_W + 1)'(N_SRC);
    win_id = win_sum[ID_W-1:0];
  end

  // Edge sources: a fresh edge in the acknowledge cycle outranks the clear.
  always_comb begin
    pend_nxt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (edge_i[i])
        pend_nxt[i] = (int_req_i[i] & ~prev[i]) |
                      (pend[i] & ~(ack_fire && (cur_id == ID_W'(i))));
      else
        pend_nxt[i] = int_req_i[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = SIGNAL;
      SIGNAL:  if (trap_ack_i)        state_nxt = ACTIVE;
               else if (!elig[cur_id]) state_nxt = IDLE;
      ACTIVE:  if (int_ret_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_o  = (state == SIGNAL);
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend      <= '0;
      prev      <= '0;
      rr_ptr    <= '0;
      cur_id    <= '0;
      mcause_o  <= '0;
      int_fin_o <= '0;
    end else begin
      pend      <= pend_nxt;
      prev      <= int_req_i;
      int_fin_o <= '0;
      if (state == IDLE && win_vld)
        cur_id <= win_id;
      if (ack_fire)
        mcause_o <= 32'h8000_0010 + {{(32 - ID_W){1'b0}}, cur_id};
      if (ret_fire) begin
        int_fin_o <= N_SRC'(1) << cur_id;
        rr_ptr    <= cur_inc;
      end
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter: directed scenarios plus randomized traffic against a
// rule-level reference model.
module tb_irq_arbiter;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic [N-1:0] int_req_i, mie_i, edge_i;
  logic         gie_i, trap_ack_i, int_ret_i;
  logic         int_o, busy_o;
  logic [31:0]  mcause_o;
  logic [N-1:0] int_fin_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = idle, 1 = signalled, 2 = in service
  int          m_phase, m_rr, m_cur;
  bit          m_pend[N];
  bit          m_prev[N];
  logic [31:0] m_mcause;
  logic [N-1:0] m_fin;

  irq_arbiter #(.N_SRC(N), .ID_W(4)) dut (
    .clk(clk), .rst_n_i(rst_n_i), .int_req_i(int_req_i), .mie_i(mie_i),
    .edge_i(edge_i), .gie_i(gie_i), .trap_ack_i(trap_ack_i), .int_ret_i(int_ret_i),
    .int_o(int_o), .mcause_o(mcause_o), .int_fin_o(int_fin_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_rr = 0; m_cur = 0; m_mcause = '0; m_fin = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
  endtask

  task automatic model_update();
    bit el[N];
    bit np[N];
    int nphase;
    bit found;
    nphase = m_phase;
    found  = 0;
    for (int i = 0; i < N; i++) begin
      el[i] = m_pend[i] && mie_i[i] && gie_i;
      if (edge_i[i])
        np[i] = (int_req_i[i] && !m_prev[i]) ||
                (m_pend[i] && !(m_phase == 1 && trap_ack_i && m_cur == i));
      else
        np[i] = int_req_i[i];
    end
    m_fin = '0;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++)
        if (!found && el[(m_rr + k) % N]) begin
          found = 1; m_cur = (m_rr + k) % N; nphase = 1;
        end
    end else if (m_phase == 1) begin
      if (trap_ack_i) begin
        m_mcause = 32'h8000_0010 + m_cur; nphase = 2;
      end else if (!el[m_cur]) nphase = 0;
    end else if (int_ret_i) begin
      m_fin = N'(1) << m_cur; m_rr = (m_cur + 1) % N; nphase = 0;
    end
    m_phase = nphase;
    for (int i = 0; i < N; i++) begin m_pend[i] = np[i]; m_prev[i] = int_req_i[i]; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; int_req_i = '0; mie_i = '0; edge_i = '0;
    gie_i = 1'b0; trap_ack_i = 1'b0; int_ret_i = 1'b0;
    model_reset();
    #2 rst_n_i = 1'b1;
  endtask

  task automatic wait_int(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (int_o === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; int_req_i = '0; mie_i = '0; edge_i = '0;
    gie_i = 1'b0; trap_ack_i = 1'b0; int_ret_i = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %b want 0", int_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (mcause_o !== 32'h0) begin n_bad++; $display("FAIL reset_mcause: got %h want 0", mcause_o); end
    n_cmp++; if (int_fin_o !== '0) begin n_bad++; $display("FAIL reset_fin: got %b want 0", int_fin_o); end
    rst_n_i = 1'b1;
    tick(); tick();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL reset_quiet: got %b want 0", int_o); end
  endtask

  task automatic test_single_level();
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b1; int_req_i = 6'b000100;
    tick();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL single_e1: got %b want 0", int_o); end
    tick();
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL single_e2: got %b want 1", int_o); end
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    n_cmp++; if (mcause_o !== 32'h8000_0012) begin n_bad++; $display("FAIL single_mcause: got %h want 80000012", mcause_o); end
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL single_int_ack: got %b want 0", int_o); end
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b000100) begin n_bad++; $display("FAIL single_fin: got %b want 000100", int_fin_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy_o); end
    tick();
    n_cmp++; if (int_fin_o !== 6'b000000) begin n_bad++; $display("FAIL single_fin_len: got %b want 0", int_fin_o); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_id;
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b1; int_req_i = 6'b010010;
    for (int j = 0; j < 4; j++) begin
      exp_id = (j % 2) ? 4 : 1;
      wait_int(6, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_timeout: service %0d never signalled", j); end
      trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
      n_cmp++; if (mcause_o !== 32'h8000_0010 + exp_id) begin n_bad++; $display("FAIL rr_order: got %h want %h", mcause_o, 32'h8000_0010 + exp_id); end
      int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
      n_cmp++; if (int_fin_o !== N'(1) << exp_id) begin n_bad++; $display("FAIL rr_fin: got %b want %b", int_fin_o, N'(1) << exp_id); end
    end
  endtask

  task automatic test_edge();
    bit ok;
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b1; edge_i = 6'b001000; int_req_i = 6'b000001;
    wait_int(4, ok);
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    n_cmp++; if (mcause_o !== 32'h8000_0010) begin n_bad++; $display("FAIL edge_src0: got %h want 80000010", mcause_o); end
    int_req_i = 6'b001000; tick();
    int_req_i = 6'b000000; tick();
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b000001) begin n_bad++; $display("FAIL edge_fin0: got %b want 000001", int_fin_o); end
    wait_int(4, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL edge_latched: got no int_o want int_o for src 3"); end
    trap_ack_i = 1'b1; int_req_i = 6'b001000; tick();
    trap_ack_i = 1'b0; int_req_i = 6'b000000;
    n_cmp++; if (mcause_o !== 32'h8000_0013) begin n_bad++; $display("FAIL edge_mcause: got %h want 80000013", mcause_o); end
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b001000) begin n_bad++; $display("FAIL edge_fin3: got %b want 001000", int_fin_o); end
    wait_int(4, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL edge_retained: got no int_o want int_o for kept edge"); end
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b001000) begin n_bad++; $display("FAIL edge_fin3b: got %b want 001000", int_fin_o); end
  endtask

  task automatic test_withdraw();
    bit ok;
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b1; int_req_i = 6'b100000;
    wait_int(4, ok);
    int_req_i = '0; tick();
    n_cmp++; if (int_o !== 1'b1) begin n_bad++; $display("FAIL wd_hold: got %b want 1", int_o); end
    tick();
    n_cmp++; if (int_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL wd_drop: got int=%b busy=%b want 0 0", int_o, busy_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (int_fin_o !== '0 || int_o !== 1'b0) begin n_bad++; $display("FAIL wd_quiet: got fin=%b int=%b want 0 0", int_fin_o, int_o); end
    end
    int_req_i = 6'b100000;
    wait_int(4, ok);
    int_req_i = '0; tick();
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1 || mcause_o !== 32'h8000_0015) begin n_bad++; $display("FAIL wd_ackwins: got busy=%b mcause=%h want 1 80000015", busy_o, mcause_o); end
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b100000) begin n_bad++; $display("FAIL wd_fin: got %b want 100000", int_fin_o); end
  endtask

  task automatic test_mask();
    bit ok;
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b0; int_req_i = 6'b000001;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL mask_gie: got %b want 0", int_o); end
    end
    gie_i = 1'b1;
    wait_int(2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mask_unmask: got no int_o want int_o within 2 cycles"); end
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    mie_i = 6'b111110; tick();
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    n_cmp++; if (int_fin_o !== 6'b000001) begin n_bad++; $display("FAIL mask_fin: got %b want 000001", int_fin_o); end
    tick();
    n_cmp++; if (int_o !== 1'b0) begin n_bad++; $display("FAIL mask_mie: got %b want 0", int_o); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    mie_i = 6'h3F; gie_i = 1'b1; int_req_i = 6'b001000;
    wait_int(4, ok);
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
    wait_int(4, ok);
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1 || mcause_o !== 32'h8000_0013) begin n_bad++; $display("FAIL ar_active: got busy=%b mcause=%h want 1 80000013", busy_o, mcause_o); end
    int_req_i = 6'b010001;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || int_o !== 1'b0) begin n_bad++; $display("FAIL ar_async: got busy=%b int=%b want 0 0", busy_o, int_o); end
    n_cmp++; if (mcause_o !== 32'h0 || int_fin_o !== '0) begin n_bad++; $display("FAIL ar_clear: got mcause=%h fin=%b want 0 0", mcause_o, int_fin_o); end
    model_reset();
    #1 rst_n_i = 1'b1;
    wait_int(4, ok);
    trap_ack_i = 1'b1; tick(); trap_ack_i = 1'b0;
    n_cmp++; if (mcause_o !== 32'h8000_0010) begin n_bad++; $display("FAIL ar_rrptr: got %h want 80000010", mcause_o); end
    int_ret_i = 1'b1; tick(); int_ret_i = 1'b0;
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) edge_i = N'($urandom);
      int_req_i  = N'($urandom);
      mie_i      = ($urandom_range(0, 9) < 8) ? 6'h3F : N'($urandom);
      gie_i      = ($urandom_range(0, 9) < 9);
      trap_ack_i = ($urandom_range(0, 9) < 3);
      int_ret_i  = ($urandom_range(0, 9) < 3);
      tick();
      n_cmp++; if (int_o !== (m_phase == 1)) begin n_bad++; if (shown++ < 10) $display("FAIL rnd_int c=%0d: got %b want %b", c, int_o, m_phase == 1); end
      n_cmp++; if (busy_o !== (m_phase != 0)) begin n_bad++; if (shown++ < 10) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy_o, m_phase != 0); end
      n_cmp++; if (mcause_o !== m_mcause) begin n_bad++; if (shown++ < 10) $display("FAIL rnd_mcause c=%0d: got %h want %h", c, mcause_o, m_mcause); end
      n_cmp++; if (int_fin_o !== m_fin) begin n_bad++; if (shown++ < 10) $display("FAIL rnd_fin c=%0d: got %b want %b", c, int_fin_o, m_fin); end
    end
    trap_ack_i = 1'b0; int_ret_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_level();
    test_round_robin();
    test_edge();
    test_withdraw();
    test_mask();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
